// File: rtl/mem_bus_arbiter.sv
// Purpose : two-master (M0 cpu, M1 debug/loader) arbiter in front of a 256x16 RAM and
//           the switch/LED MMIO; round-robin, one transaction in flight at a time.
// Latency : grant is combinational in the request cycle; read data returns one cycle later.
//           Writes sustain one per cycle, reads one per two cycles.
// Backpressure: a master holds cmd/addr/wdata until it sees its gnt pulse; no grants are
//           issued while a read is waiting for its data.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   mX_cmd/addr/wdata           master requests (01 read, 10 write, 00/11 idle)
//   mX_gnt, mX_rvalid, mX_rdata request accepted pulse, read data pulse and data
//   ram_*                       RAM read/write ports (ram_dout has 1-cycle latency)
//   sw, led                     switch inputs and LED register
module mem_bus_arbiter #(
    parameter logic [8:0] SW_ADDR  = 9'h140,
    parameter logic [8:0] LED_ADDR = 9'h100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  m0_cmd,
    input  logic [8:0]  m0_addr,
    input  logic [15:0] m0_wdata,
    input  logic [1:0]  m1_cmd,
    input  logic [8:0]  m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [15:0] m0_rdata,
    output logic [15:0] m1_rdata,
    output logic [7:0]  ram_read_address,
    output logic [7:0]  ram_write_address,
    output logic        ram_write,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout,
    input  logic [7:0]  sw,
    output logic [7:0]  led
);

    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;        // master that wins when both request
    logic [7:0]  led_q, led_d;
    logic        rd_id_q, rd_id_d;      // master owning the outstanding read
    logic        rd_ram_q, rd_ram_d;    // outstanding read targets RAM (else MMIO)
    logic [15:0] rd_mmio_q, rd_mmio_d;  // MMIO value captured at grant time

    logic        req0, req1;
    logic        win;
    logic        gnt_any;
    logic [1:0]  w_cmd;
    logic [8:0]  w_addr;
    logic [15:0] w_wdata;
    logic        rv_any;
    logic [15:0] rd_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            led_q     <= 8'h00;
            rd_id_q   <= 1'b0;
            rd_ram_q  <= 1'b0;
            rd_mmio_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            led_q     <= led_d;
            rd_id_q   <= rd_id_d;
            rd_ram_q  <= rd_ram_d;
            rd_mmio_q <= rd_mmio_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        led_d     = led_q;
        rd_id_d   = rd_id_q;
        rd_ram_d  = rd_ram_q;
        rd_mmio_d = rd_mmio_q;

        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        ram_write = 1'b0;

        // Reset masks requests so nothing is granted or written in a reset cycle.
        req0 = !reset && (state_q == IDLE) && (m0_cmd == MREAD || m0_cmd == MWRITE);
        req1 = !reset && (state_q == IDLE) && (m1_cmd == MREAD || m1_cmd == MWRITE);

        if (req0 && req1) begin
            win = prio_q;
        end else begin
            win = req1;
        end
        gnt_any = req0 || req1;

        w_cmd   = win ? m1_cmd   : m0_cmd;
        w_addr  = win ? m1_addr  : m0_addr;
        w_wdata = win ? m1_wdata : m0_wdata;

        // RAM ports always follow the current winner's request; only the write
        // enable is qualified, so the addresses never float to X.
        ram_read_address  = w_addr[7:0];
        ram_write_address = w_addr[7:0];
        ram_din           = w_wdata;

        if (gnt_any) begin
            m0_gnt = !win;
            m1_gnt = win;
            prio_d = !win;
            if (w_cmd == MWRITE) begin
                ram_write = !w_addr[8];
                if (w_addr == LED_ADDR) begin
                    led_d = w_wdata[7:0];
                end
            end else begin
                state_d   = RD_WAIT;
                rd_id_d   = win;
                rd_ram_d  = !w_addr[8];
                rd_mmio_d = (w_addr == SW_ADDR) ? {8'h00, sw} : 16'h0000;
            end
        end

        if (state_q == RD_WAIT) begin
            state_d = IDLE;
        end

        // A read pending when reset arrives is dropped: no rvalid in that cycle.
        rv_any    = (state_q == RD_WAIT) && !reset;
        rd_val    = rd_ram_q ? ram_dout : rd_mmio_q;
        m0_rvalid = rv_any && !rd_id_q;
        m1_rvalid = rv_any && rd_id_q;
        m0_rdata  = m0_rvalid ? rd_val : 16'h0000;
        m1_rdata  = m1_rvalid ? rd_val : 16'h0000;
    end

    assign led = led_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m0_cmd, m1_cmd;
    logic [8:0]  m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic [7:0]  ram_read_address, ram_write_address;
    logic        ram_write;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [7:0]  sw;
    logic [7:0]  led;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .m0_cmd            (m0_cmd),
        .m0_addr           (m0_addr),
        .m0_wdata          (m0_wdata),
        .m1_cmd            (m1_cmd),
        .m1_addr           (m1_addr),
        .m1_wdata          (m1_wdata),
        .m0_gnt            (m0_gnt),
        .m1_gnt            (m1_gnt),
        .m0_rvalid         (m0_rvalid),
        .m1_rvalid         (m1_rvalid),
        .m0_rdata          (m0_rdata),
        .m1_rdata          (m1_rdata),
        .ram_read_address  (ram_read_address),
        .ram_write_address (ram_write_address),
        .ram_write         (ram_write),
        .ram_din           (ram_din),
        .ram_dout          (ram_dout),
        .sw                (sw),
        .led               (led)
    );

    // Behavioural 256x16 RAM with registered read.
    logic [15:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        ram_dout = 16'h0000;
    end
    always @(posedge clk) begin
        if (ram_write === 1'b1) mem[ram_write_address] <= ram_din;
        ram_dout <= mem[ram_read_address];
    end

    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b10;
    localparam logic [1:0] NO = 2'b00;

    typedef struct {
        string       name;
        logic [1:0]  gnt;   // {m1_gnt, m0_gnt}
        logic [1:0]  rv;    // {m1_rvalid, m0_rvalid}
        logic [15:0] rd0;
        logic [15:0] rd1;
        logic        wr;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    task automatic push(input string n, input logic [1:0] g, input logic [1:0] rv,
                        input logic [15:0] r0, input logic [15:0] r1, input logic wr);
        exp_t x;
        x.name = n; x.gnt = g; x.rv = rv; x.rd0 = r0; x.rd1 = r1; x.wr = wr;
        exp_q.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: every cycle with a grant or read return consumes one expectation;
    // quiet cycles must not write the RAM.
    always @(negedge clk) begin
        if (mon_en) begin
            if ((m0_gnt | m1_gnt | m0_rvalid | m1_rvalid) !== 1'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event @%0t: gnt=%b%b rv=%b%b", $time,
                             m1_gnt, m0_gnt, m1_rvalid, m0_rvalid);
                end else begin
                    e = exp_q.pop_front();
                    if ({m1_gnt, m0_gnt} !== e.gnt || {m1_rvalid, m0_rvalid} !== e.rv ||
                        m0_rdata !== e.rd0 || m1_rdata !== e.rd1 || ram_write !== e.wr) begin
                        n_err++;
                        $display("FAIL %s @%0t: got gnt=%b%b rv=%b%b rd0=%h rd1=%h wr=%b expected gnt=%b rv=%b rd0=%h rd1=%h wr=%b",
                                 e.name, $time, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid,
                                 m0_rdata, m1_rdata, ram_write, e.gnt, e.rv, e.rd0, e.rd1, e.wr);
                    end
                end
            end else begin
                n_cmp++;
                if (ram_write !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_ram_write @%0t: got %b expected 0", $time, ram_write);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        m0_cmd = NO; m1_cmd = NO;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        sw = 8'h00;

        // Reset beats a pending write request.
        cyc();
        mon_en = 1'b1;
        m0_cmd = WR; m0_addr = 9'h005; m0_wdata = 16'hDEAD;
        @(negedge clk);
        chk("reset_no_gnt", {14'h0, m1_gnt, m0_gnt}, 16'h0000);
        chk("reset_no_write", {15'h0, ram_write}, 16'h0000);
        cyc();
        m0_cmd = NO;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_led", {8'h00, led}, 16'h0000);

        // 1: RAM write then read back.
        cyc();
        m0_cmd = WR; m0_addr = 9'h005; m0_wdata = 16'hBEEF;
        push("t1_wr_gnt", 2'b01, 2'b00, 16'h0, 16'h0, 1'b1);
        cyc();
        m0_cmd = RD;
        push("t1_rd_gnt", 2'b01, 2'b00, 16'h0, 16'h0, 1'b0);
        push("t1_rd_data", 2'b00, 2'b01, 16'hBEEF, 16'h0, 1'b0);
        cyc();
        m0_cmd = NO;
        cyc();

        // 2: MMIO reads from M1.
        sw = 8'hA5;
        m1_cmd = RD; m1_addr = 9'h140;
        push("t2_sw_gnt", 2'b10, 2'b00, 16'h0, 16'h0, 1'b0);
        push("t2_sw_data", 2'b00, 2'b10, 16'h0, 16'h00A5, 1'b0);
        cyc();
        m1_cmd = NO;
        cyc();
        m1_cmd = RD; m1_addr = 9'h1FF;
        push("t2_1ff_gnt", 2'b10, 2'b00, 16'h0, 16'h0, 1'b0);
        push("t2_1ff_data", 2'b00, 2'b10, 16'h0, 16'h0000, 1'b0);
        cyc();
        m1_cmd = NO;
        cyc();

        // 3: LED write does not touch the RAM.
        m0_cmd = WR; m0_addr = 9'h100; m0_wdata = 16'h1234;
        push("t3_led_gnt", 2'b01, 2'b00, 16'h0, 16'h0, 1'b0);
        cyc();
        m0_cmd = NO;
        @(negedge clk);
        chk("t3_led", {8'h00, led}, 16'h0034);

        // Read-after-write to the same address on consecutive cycles.
        cyc();
        m0_cmd = WR; m0_addr = 9'h022; m0_wdata = 16'h5A5A;
        push("raw_wr_gnt", 2'b01, 2'b00, 16'h0, 16'h0, 1'b1);
        cyc();
        m0_cmd = RD;
        push("raw_rd_gnt", 2'b01, 2'b00, 16'h0, 16'h0, 1'b0);
        push("raw_rd_data", 2'b00, 2'b01, 16'h5A5A, 16'h0, 1'b0);
        cyc();
        m0_cmd = NO;
        cyc();

        // 4: both masters hold reads after reset -> M0,M1,M0,M1 every two cycles.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        m0_cmd = RD; m0_addr = 9'h005;
        m1_cmd = RD; m1_addr = 9'h140;
        for (int i = 0; i < 2; i++) begin
            push("t4_rd_gnt_m0", 2'b01, 2'b00, 16'h0, 16'h0, 1'b0);
            push("t4_rd_data_m0", 2'b00, 2'b01, 16'hBEEF, 16'h0, 1'b0);
            push("t4_rd_gnt_m1", 2'b10, 2'b00, 16'h0, 16'h0, 1'b0);
            push("t4_rd_data_m1", 2'b00, 2'b10, 16'h0, 16'h00A5, 1'b0);
        end
        repeat (8) cyc();
        m0_cmd = NO; m1_cmd = NO;
        @(negedge clk);
        chk("t4_led_after_reset", {8'h00, led}, 16'h0000);
        cyc();

        // Both hold writes -> alternating grants every cycle, M0 first (prio back to 0).
        m0_cmd = WR; m0_addr = 9'h010; m0_wdata = 16'h1111;
        m1_cmd = WR; m1_addr = 9'h011; m1_wdata = 16'h2222;
        for (int i = 0; i < 2; i++) begin
            push("t4_wr_gnt_m0", 2'b01, 2'b00, 16'h0, 16'h0, 1'b1);
            push("t4_wr_gnt_m1", 2'b10, 2'b00, 16'h0, 16'h0, 1'b1);
        end
        repeat (4) cyc();
        m0_cmd = NO;
        m1_cmd = RD;
        push("t4_rb_gnt", 2'b10, 2'b00, 16'h0, 16'h0, 1'b0);
        push("t4_rb_data", 2'b00, 2'b10, 16'h0, 16'h2222, 1'b0);
        cyc();
        m1_cmd = NO;
        cyc();

        // 5: reset during RD_WAIT drops the read and clears led and prio.
        m1_cmd = WR; m1_addr = 9'h100; m1_wdata = 16'h00C3;
        push("t5_led_gnt", 2'b10, 2'b00, 16'h0, 16'h0, 1'b0);
        cyc();
        m1_cmd = NO;
        @(negedge clk);
        chk("t5_led_set", {8'h00, led}, 16'h00C3);
        cyc();
        m0_cmd = RD; m0_addr = 9'h005;
        push("t5_rd_gnt", 2'b01, 2'b00, 16'h0, 16'h0, 1'b0);
        cyc();
        m0_cmd = NO;
        reset = 1'b1;
        @(negedge clk);
        chk("t5_no_rvalid", {14'h0, m1_rvalid, m0_rvalid}, 16'h0000);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_led_cleared", {8'h00, led}, 16'h0000);
        cyc();
        m0_cmd = RD; m0_addr = 9'h010;
        m1_cmd = RD; m1_addr = 9'h011;
        push("t5_next_gnt_m0", 2'b01, 2'b00, 16'h0, 16'h0, 1'b0);
        push("t5_next_data", 2'b00, 2'b01, 16'h1111, 16'h0, 1'b0);
        cyc();
        m0_cmd = NO; m1_cmd = NO;
        cyc();

        // 6: M1 requests during M0's RD_WAIT then withdraws -> never granted.
        m0_cmd = RD; m0_addr = 9'h011;
        push("t6_gnt_m0", 2'b01, 2'b00, 16'h0, 16'h0, 1'b0);
        push("t6_data_m0", 2'b00, 2'b01, 16'h2222, 16'h0, 1'b0);
        cyc();
        m0_cmd = NO;
        m1_cmd = WR; m1_addr = 9'h005; m1_wdata = 16'hFFFF;
        cyc();
        m1_cmd = NO;
        repeat (3) cyc();
        chk("t6_ram_untouched", mem[5], 16'hBEEF);

        // Every expected event must have been seen.
        chk("scoreboard_drained", exp_q.size(), 16'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
